// File: rtl/ascii_grid_loader_pkg.sv
// Shared constants and enums for the ASCII grid loader.
// The enum encodings are the values that appear on the err_code output.
package ascii_grid_loader_pkg;

  localparam logic [7:0] CH_AT  = 8'h40;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_CHAR   = 2'd1,
    ERR_ROW_LEN    = 2'd2,
    ERR_EARLY_LAST = 2'd3
  } err_e;

endpackage

// File: rtl/ascii_grid_loader_decoder.sv
// Combinational byte classifier for the grid loader.
// Every byte value raises exactly one of is_cell, is_lf, is_skip or is_bad.
module ascii_cell_decoder
  import ascii_grid_loader_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_cell,
  output logic       cell_bit,
  output logic       is_lf,
  output logic       is_skip,
  output logic       is_bad
);

  always_comb begin
    is_cell  = (data == CH_AT) || (data == CH_DOT);
    cell_bit = (data == CH_AT);
    is_lf    = (data == CH_LF);
    is_skip  = (data == CH_CR);
    is_bad   = !(is_cell || is_lf || is_skip);
  end

endmodule

// File: rtl/ascii_grid_loader.sv
// Byte stream to packed occupancy bitmap, with row geometry checks and '@' count.
//   state | meaning
//   LOAD  | accepting bytes, filling bitmap
//   HOLD  | grid complete, held until grid_ack
//   ERR   | sticky fault, bytes drained until rst
module ascii_grid_loader
  import ascii_grid_loader_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic [WIDTH*DEPTH-1:0] grid_out,
  output logic                   grid_valid,
  input  logic                   grid_ack,
  output logic [31:0]            cell_count,
  output logic                   error,
  output logic [1:0]             err_code
);

  localparam int NCELL = WIDTH * DEPTH;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int RW    = $clog2(DEPTH + 1);
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] COL_END  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [NCELL-1:0]   grid_q, grid_d;
  logic [31:0]        count_q, count_d;
  logic               error_q, error_d;
  err_e               code_q, code_d;

  logic               is_cell, cell_bit, is_lf, is_skip, is_bad;
  logic               accept;
  logic               done;
  err_e               fault;
  logic [IW-1:0]      cell_idx;

  ascii_cell_decoder u_decoder (
    .data     (in_data),
    .is_cell  (is_cell),
    .cell_bit (cell_bit),
    .is_lf    (is_lf),
    .is_skip  (is_skip),
    .is_bad   (is_bad)
  );

  // rst gates ready directly so no byte is taken during the reset cycle
  assign in_ready   = !rst && (state_q != ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign cell_idx   = IW'(row_q) * IW'(WIDTH) + IW'(col_q);

  assign grid_out   = grid_q;
  assign grid_valid = (state_q == ST_HOLD);
  assign cell_count = count_q;
  assign error      = error_q;
  assign err_code   = code_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    grid_d  = grid_q;
    count_d = count_q;
    error_d = error_q;
    code_d  = code_q;
    fault   = ERR_NONE;
    done    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (is_skip) begin
            // CR of CRLF line endings carries no information
          end else if (is_cell) begin
            if (col_q == COL_FULL) begin
              fault = ERR_ROW_LEN;
            end else begin
              grid_d[cell_idx] = cell_bit;
              col_d = col_q + 1'b1;
              if (cell_bit) count_d = count_q + 32'd1;
              // a final row may end at its last cell when the source marks it last
              if ((row_q == ROW_END) && (col_q == COL_END)) done = in_last;
            end
          end else if (is_lf) begin
            if (col_q == COL_FULL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
              if (row_q == ROW_END) done = 1'b1;
            end else if (col_q != '0) begin
              fault = ERR_ROW_LEN;
            end
          end else if (is_bad) begin
            fault = ERR_BAD_CHAR;
          end

          if ((fault == ERR_NONE) && in_last && !done) fault = ERR_EARLY_LAST;

          if (fault != ERR_NONE) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            code_d  = fault;
          end else if (done) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (grid_ack) begin
          state_d = ST_LOAD;
          row_d   = '0;
          col_d   = '0;
          grid_d  = '0;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      row_q   <= '0;
      col_q   <= '0;
      grid_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grid_q  <= grid_d;
      count_q <= count_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_ascii_grid_loader.sv
// Directed bench for ascii_grid_loader: sample grid, CRLF/blank/gaps, hold/ack,
// geometry and character faults, early in_last and reset behaviour.
module tb_ascii_grid_loader;

  localparam int WIDTH = 10;
  localparam int DEPTH = 10;
  localparam int NCELL = WIDTH * DEPTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [NCELL-1:0] grid_out;
  logic             grid_valid;
  logic             grid_ack;
  logic [31:0]      cell_count;
  logic             error;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  string sample [DEPTH] = '{
    "..@@.@@@@.",
    "@@@.@.@.@@",
    "@@@@@.@.@@",
    "@.@@@@..@.",
    "@@.@@@@.@@",
    ".@@@@@@@.@",
    ".@.@.@.@@@",
    "@.@@@.@@@@",
    ".@@@@@@@@.",
    "@.@.@@@.@."
  };

  ascii_grid_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .grid_out   (grid_out),
    .grid_valid (grid_valid),
    .grid_ack   (grid_ack),
    .cell_count (cell_count),
    .error      (error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // kind 0: puzzle sample, kind 1: diagonal of '@'
  function automatic logic [7:0] cell_char(input int kind, input int r, input int c);
    string s;
    if (kind == 0) begin
      s = sample[r];
      return s[c];
    end
    return (r == c) ? 8'h40 : 8'h2E;
  endfunction

  function automatic logic [NCELL-1:0] exp_grid(input int kind);
    logic [NCELL-1:0] g = '0;
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < WIDTH; c++)
        g[r*WIDTH+c] = (cell_char(kind, r, c) == 8'h40);
    return g;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic l, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_eol(input bit crlf, input logic l, input bit gaps);
    if (crlf) send_byte(8'h0D, 1'b0, gaps);
    send_byte(8'h0A, l, gaps);
  endtask

  // in_last goes on the LF of the final row sent when last_on_final is set
  task automatic send_grid(input int kind, input int nrows, input bit crlf,
                           input int blank_after, input bit gaps, input bit last_on_final);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < WIDTH; c++) send_byte(cell_char(kind, r, c), 1'b0, gaps);
      if (r == nrows - 1 && last_on_final) chk("valid_before_last", grid_valid, 0);
      send_eol(crlf, (r == nrows - 1) && last_on_final, gaps);
      if (r == blank_after) send_eol(crlf, 1'b0, gaps);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int ready_hi;
    logic [NCELL-1:0] held;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    grid_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", grid_valid, 0);
    chk("reset_grid", grid_out, 0);
    chk("reset_count", cell_count, 0);
    chk("reset_error", error, 0);
    chk("reset_code", err_code, 0);

    // 1: plain sample
    send_grid(0, DEPTH, 1'b0, -1, 1'b0, 1'b1);
    chk("t1_valid", grid_valid, 1);
    chk("t1_count", cell_count, 71);
    chk("t1_bit2", grid_out[2], 1);
    chk("t1_bit0", grid_out[0], 0);
    chk("t1_bit99", grid_out[99], 0);
    chk("t1_grid", grid_out, exp_grid(0));
    chk("t1_error", error, 0);
    chk("t1_ready", in_ready, 0);

    // 2: CRLF, blank line after row 4, random gaps
    do_reset();
    send_grid(0, DEPTH, 1'b1, 4, 1'b1, 1'b1);
    chk("t2_valid", grid_valid, 1);
    chk("t2_grid", grid_out, exp_grid(0));
    chk("t2_count", cell_count, 71);

    // 3: hold with source stalled, then ack and reload
    held = grid_out;
    ready_hi = 0;
    in_valid = 1'b1;
    in_data = 8'h40;
    repeat (20) begin
      @(negedge clk);
      if (in_ready) ready_hi++;
    end
    chk("t3_hold_ready", ready_hi, 0);
    chk("t3_hold_grid", grid_out, held);
    chk("t3_hold_valid", grid_valid, 1);
    chk("t3_hold_count", cell_count, 71);
    in_valid = 1'b0;
    grid_ack = 1'b1;
    @(posedge clk);
    #1;
    grid_ack = 1'b0;
    chk("t3_ack_valid", grid_valid, 0);
    chk("t3_ack_count", cell_count, 0);
    chk("t3_ack_ready", in_ready, 1);
    chk("t3_ack_grid", grid_out, 0);
    send_grid(1, DEPTH, 1'b0, -1, 1'b0, 1'b1);
    chk("t3_reload_valid", grid_valid, 1);
    chk("t3_reload_grid", grid_out, exp_grid(1));
    chk("t3_reload_count", cell_count, 10);

    // 4: short first row
    do_reset();
    for (int c = 0; c < WIDTH - 1; c++) send_byte(cell_char(0, 0, c), 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    chk("t4_error", error, 1);
    chk("t4_code", err_code, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_valid", grid_valid, 0);
    chk("t4_ready", in_ready, 1);

    // 5: bad char at row 3 col 4, then a short row, then reset and reload
    do_reset();
    send_grid(0, 3, 1'b0, -1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) send_byte(cell_char(0, 3, c), 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0);
    chk("t5_error", error, 1);
    chk("t5_code", err_code, 1);
    for (int c = 0; c < 3; c++) send_byte(8'h2E, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    chk("t5_code_kept", err_code, 1);
    chk("t5_valid", grid_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_error", error, 0);
    chk("t5_rst_code", err_code, 0);
    chk("t5_rst_count", cell_count, 0);
    chk("t5_rst_grid", grid_out, 0);
    chk("t5_rst_valid", grid_valid, 0);
    chk("t5_rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    send_grid(0, DEPTH, 1'b0, -1, 1'b0, 1'b1);
    chk("t5_reload_valid", grid_valid, 1);
    chk("t5_reload_count", cell_count, 71);

    // 6: in_last too early, then reset in the middle of a hold
    do_reset();
    send_grid(0, 8, 1'b0, -1, 1'b0, 1'b1);
    chk("t6_error", error, 1);
    chk("t6_code", err_code, 3);
    chk("t6_valid", grid_valid, 0);
    do_reset();
    send_grid(0, DEPTH, 1'b0, -1, 1'b0, 1'b1);
    chk("t6_hold_valid", grid_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_valid", grid_valid, 0);
    chk("t6_rst_grid", grid_out, 0);
    chk("t6_rst_count", cell_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
